lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store initiator that converts single-outstanding core memory requests into cycles on the team's word-addressed synchronous memory model. Loads and stores can be byte, half-word or word sized. The memory side has one write enable and a registered read port with one cycle of read latency, and it writes whole words only. Sub-word stores are therefore done as read-modify-write. The block sits between the core's execute/memory stage and the `mem` instance.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the byte address on both sides.

Ports:
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `rst_n_i`, input, 1: reset. Asynchronous, active-low.
- `req_valid_i`, input, 1: core request valid.
- `req_ready_o`, output, 1: block can accept a request. High only in IDLE.
- `req_we_i`, input, 1: 1 = store, 0 = load.
- `req_size_i`, input, 2: 00 = byte, 01 = half-word, 10 = word, 11 = illegal.
- `req_unsigned_i`, input, 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr_i`, input, ADDR_W: byte address.
- `req_wdata_i`, input, 32: store data, right-aligned.
- `resp_valid_o`, output, 1: one-cycle completion pulse. There is no back-pressure, and the core must take the response in that cycle.
- `resp_rdata_o`, output, 32: extended load data. Value is 0 for stores and errors.
- `resp_err_o`, output, 1: misaligned access or illegal size.
- `mem_wen_o`, output, 1: memory write enable.
- `mem_addr_o`, output, ADDR_W: memory byte address, always with bits [1:0] = 00.
- `mem_wdata_o`, output, 32: memory write data.
- `mem_rdata_i`, input, 32: memory read data. It is valid in the cycle after an address is presented with `mem_wen_o` = 0.

## Operation
- State machine states: IDLE, RD_ISSUE, RD_DATA, WR, RESP.
- A request is accepted on a clock edge where `req_valid_i` and `req_ready_o` are both high. At that edge the block captures `we`, `size`, `unsigned`, `addr` and `wdata`.
- Error check at accept. Any of the following goes IDLE to RESP with `resp_err_o` = 1, `resp_rdata_o` = 0 and no memory access:
  - size 11;
  - half-word with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0.
- Word store: IDLE to WR to RESP.
- Load, or sub-word store: IDLE to RD_ISSUE to RD_DATA. From RD_DATA:
  - a load goes to RESP;
  - a sub-word store goes to WR and then RESP.
- RESP always returns to IDLE.
- Data lanes are little-endian:
  - the byte lane is selected by `addr[1:0]`;
  - the half-word lane is selected by `addr[1]` (bits [15:0] or [31:16]).
- Load extraction: shift the selected lane to bit 0, then sign- or zero-extend it to 32 bits.
- Store merge: replace only the selected lane of the sampled `mem_rdata_i` with `wdata[7:0]` or `wdata[15:0]`. All other bytes keep their read value.
- `mem_addr_o` equals `{addr[ADDR_W-1:2], 2'b00}` from RD_ISSUE through WR. It holds its last value in IDLE and RESP.
- `mem_wen_o` is 1 only in WR. `mem_wdata_o` is valid in WR.
- `mem_addr_o`, `mem_wdata_o` and `mem_wen_o` are driven from registers.

## Timing
- Call the accept edge E0. The request cycle is cycle 0, and cycle n follows edge En-1.
- Word store:
  - WR in cycle 1;
  - memory writes at E2;
  - `resp_valid_o` in cycle 2.
- Load:
  - address on the memory bus in cycle 1;
  - `mem_rdata_i` sampled in cycle 2;
  - `resp_valid_o` and data in cycle 3.
- Sub-word store:
  - read in cycles 1–2;
  - WR in cycle 3 with the merged word;
  - `resp_valid_o` in cycle 4.
- Error: `resp_valid_o` in cycle 1.
- `req_ready_o` is low from E0 until the block returns to IDLE after RESP.
  - Back-to-back requests therefore need at least two cycles between accept edges.
  - `req_valid_i` asserted during RESP is ignored, not queued.
- Reset values: state IDLE, `req_ready_o` 1, and the following outputs 0: `resp_valid_o`, `resp_rdata_o`, `resp_err_o`, `mem_wen_o`, `mem_addr_o`, `mem_wdata_o`.
- Reset mid-operation: all registers clear immediately without waiting for a clock edge.
  - `mem_wen_o` drops at once, so a pending write whose write edge has not yet occurred is cancelled.
  - No response is issued for an aborted request.

## Structure
- Shared package `lsu_pkg` holds:
  - the `lsu_size_e` enum (BYTE, HALF, WORD, ILLEGAL);
  - the `lsu_state_e` enum;
  - a function `lsu_misaligned(size, addr_lo)`.
- One combinational sub-module, `lsu_lane`, does both load extraction/extension and store merging, given size, offset and unsigned. The FSM and all registers stay in `lsu_mem_port`.

## Test plan
Memory is preloaded with word 0x10 = 0x8899AABB.
- LW 0x10 → `resp_valid_o` in cycle 3, rdata 0x8899AABB, err 0, `mem_wen_o` never high.
- LB 0x13 → 0xFFFFFF88. LBU 0x13 → 0x00000088. LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB.
- SB 0x11, wdata 0x123456CC → `mem_wen_o` high only in cycle 3, with `mem_addr_o` 0x10 and `mem_wdata_o` 0x8899CCBB. Response in cycle 4. A following LW 0x10 returns 0x8899CCBB.
- SW 0x20, wdata 0xDEADBEEF → one write cycle in cycle 1, response in cycle 2. A following LW 0x20 returns 0xDEADBEEF.
- LH 0x11, SW 0x22 and size 11 → each gives a response in cycle 1 with err 1 and rdata 0. `mem_wen_o` stays 0 and `mem_addr_o` is unchanged.
- SH 0x12, wdata 0x0000BEEF with `rst_n_i` pulsed low during WR → `mem_wen_o` falls immediately and no `resp_valid_o` is issued. Word 0x10 stays 0x8899AABB. `req_ready_o` is 1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory port: access-size encoding,
// FSM states and the alignment check done when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR,
        RESP
    } lsu_state_e;

    // Illegal size is reported separately; this only covers alignment.
    function automatic logic lsu_misaligned(lsu_size_e size, logic [1:0] addr_lo);
        case (size)
            HALF:    return addr_lo[0];
            WORD:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: extracts and extends load data from a memory
// word, and merges sub-word store data into the word that was read.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  bit_off;

    assign bit_off = {off_i, 3'b000};

    always_comb begin
        byte_v = rdata_i[bit_off +: 8];
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (lsu_size_e'(size_i))
            BYTE:    load_o = {{24{~uns_i & byte_v[7]}}, byte_v};
            HALF:    load_o = {{16{~uns_i & half_v[15]}}, half_v};
            default: load_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_o = rdata_i;
        case (lsu_size_e'(size_i))
            BYTE: merge_o[bit_off +: 8] = wdata_i[7:0];
            HALF: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            WORD:    merge_o = wdata_i;
            default: merge_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator onto a word-wide synchronous memory
// with one cycle of read latency; sub-word stores are done as read-modify-write.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              err_d;
    logic [ADDR_W-1:0] word_addr_d;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign err_d = (lsu_size_e'(req_size_i) == ILLEGAL)
                 | lsu_misaligned(lsu_size_e'(req_size_i), req_addr_i[1:0]);
    assign word_addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};

    lsu_lane u_lane (
        .size_i  (size_q),
        .off_i   (off_q),
        .uns_i   (uns_q),
        .rdata_i (mem_rdata_i),
        .wdata_i (wdata_q),
        .load_o  (load_data),
        .merge_o (merge_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        off_q   <= req_addr_i[1:0];
                        wdata_q <= req_wdata_i;
                        if (err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else if (req_we_i && lsu_size_e'(req_size_i) == WORD) begin
                            mem_addr_q  <= word_addr_d;
                            mem_wdata_q <= req_wdata_i;
                            mem_wen_q   <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            mem_addr_q <= word_addr_d;
                            state_q    <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: state_q <= RD_DATA;
                // Read word is on mem_rdata_i now: finish the load or build the merged store word.
                RD_DATA: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_data;
                        mem_wen_q   <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                        state_q      <= RESP;
                    end
                end
                WR: begin
                    mem_wen_q    <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_wen_o    = mem_wen_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port against a word-addressed memory model
// with one cycle of registered read latency.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] wm;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(32)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .mem_wen_o      (mem_wen),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en)        mem[pl_idx] <= pl_val;
        else if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Drives one request and watches the bus until the response pulse (bounded).
    task automatic do_req(input req_t r, output int lat, output logic [31:0] rd,
                          output logic er, output logic [15:0] wm, output logic [31:0] wa,
                          output logic [31:0] wdo, output logic [31:0] a1, output logic rl);
        @(negedge clk);
        req_we = r.we; req_size = r.sz; req_uns = r.uns;
        req_addr = r.addr; req_wdata = r.wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = '0; er = 1'b0; wm = '0; wa = '0; wdo = '0; a1 = '0; rl = 1'b1;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) a1 = mem_addr;
            if (mem_wen) begin wm[n] = 1'b1; wa = mem_addr; wdo = mem_wdata; end
            if (req_ready) rl = 1'b0;
            if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        #12;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %b want 1", req_ready); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got %b want 0", resp_valid); end
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset resp_rdata got %h want 0", resp_rdata); end
        if (resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err got %b want 0", resp_err); end
        if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset mem_wen got %b want 0", mem_wen); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata got %h want 0", mem_wdata); end
        checks += 7;
        @(negedge clk) rst_n = 1'b1;
        preload(6'd4, 32'h8899AABB);
    endtask

    task automatic test_loads();
        req_t r[5];
        int lat; logic [31:0] rd, wa, wdo, a1; logic er, rl; logic [15:0] wm; exp_t e;
        r[0] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
        r[1] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0};
        r[2] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0};
        r[3] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0};
        r[4] = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0};
        exp_q.push_back('{3, 32'h8899AABB, 1'b0, 16'h0, 32'h0, 32'h0});
        exp_q.push_back('{3, 32'hFFFFFF88, 1'b0, 16'h0, 32'h0, 32'h0});
        exp_q.push_back('{3, 32'h00000088, 1'b0, 16'h0, 32'h0, 32'h0});
        exp_q.push_back('{3, 32'hFFFF8899, 1'b0, 16'h0, 32'h0, 32'h0});
        exp_q.push_back('{3, 32'h0000AABB, 1'b0, 16'h0, 32'h0, 32'h0});
        for (int i = 0; i < 5; i++) begin
            do_req(r[i], lat, rd, er, wm, wa, wdo, a1, rl);
            e = exp_q.pop_front();
            if (lat !== e.lat) begin errors++; $display("FAIL load[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errors++; $display("FAIL load[%0d] rdata got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errors++; $display("FAIL load[%0d] err got %b want %b", i, er, e.err); end
            if (wm !== e.wm) begin errors++; $display("FAIL load[%0d] wen cycles got %h want %h", i, wm, e.wm); end
            if (a1 !== 32'h10) begin errors++; $display("FAIL load[%0d] cycle1 mem_addr got %h want 10", i, a1); end
            if (rl !== 1'b1) begin errors++; $display("FAIL load[%0d] ready low got %b want 1", i, rl); end
            checks += 6;
        end
    endtask

    task automatic test_stores();
        req_t r[4];
        int lat; logic [31:0] rd, wa, wdo, a1; logic er, rl; logic [15:0] wm; exp_t e;
        r[0] = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC};
        r[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
        r[2] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF};
        r[3] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0};
        exp_q.push_back('{4, 32'h0, 1'b0, 16'h0008, 32'h10, 32'h8899CCBB});
        exp_q.push_back('{3, 32'h8899CCBB, 1'b0, 16'h0, 32'h0, 32'h0});
        exp_q.push_back('{2, 32'h0, 1'b0, 16'h0002, 32'h20, 32'hDEADBEEF});
        exp_q.push_back('{3, 32'hDEADBEEF, 1'b0, 16'h0, 32'h0, 32'h0});
        for (int i = 0; i < 4; i++) begin
            do_req(r[i], lat, rd, er, wm, wa, wdo, a1, rl);
            e = exp_q.pop_front();
            if (lat !== e.lat) begin errors++; $display("FAIL store[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errors++; $display("FAIL store[%0d] rdata got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errors++; $display("FAIL store[%0d] err got %b want %b", i, er, e.err); end
            if (wm !== e.wm) begin errors++; $display("FAIL store[%0d] wen cycles got %h want %h", i, wm, e.wm); end
            if (wa !== e.waddr) begin errors++; $display("FAIL store[%0d] write addr got %h want %h", i, wa, e.waddr); end
            if (wdo !== e.wdata) begin errors++; $display("FAIL store[%0d] write data got %h want %h", i, wdo, e.wdata); end
            if (rl !== 1'b1) begin errors++; $display("FAIL store[%0d] ready low got %b want 1", i, rl); end
            checks += 7;
        end
    endtask

    task automatic test_errors();
        req_t r[3];
        int lat; logic [31:0] rd, wa, wdo, a1; logic er, rl; logic [15:0] wm; exp_t e;
        r[0] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0};
        r[1] = '{1'b1, 2'b10, 1'b0, 32'h22, 32'h55AA55AA};
        r[2] = '{1'b0, 2'b11, 1'b0, 32'h24, 32'h0};
        for (int i = 0; i < 3; i++) exp_q.push_back('{1, 32'h0, 1'b1, 16'h0, 32'h0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            do_req(r[i], lat, rd, er, wm, wa, wdo, a1, rl);
            e = exp_q.pop_front();
            if (lat !== e.lat) begin errors++; $display("FAIL err[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errors++; $display("FAIL err[%0d] rdata got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errors++; $display("FAIL err[%0d] err got %b want %b", i, er, e.err); end
            if (wm !== e.wm) begin errors++; $display("FAIL err[%0d] wen cycles got %h want %h", i, wm, e.wm); end
            if (a1 !== 32'h20) begin errors++; $display("FAIL err[%0d] mem_addr got %h want 20", i, a1); end
            checks += 5;
        end
    endtask

    // Valid raised during RESP must be dropped, not queued.
    task automatic test_resp_ignore();
        int bad = 0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899CCBB) begin
            errors++; $display("FAIL resp_ignore load valid/rdata got %b/%h want 1/8899ccbb", resp_valid, resp_rdata);
        end
        checks++;
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_wen !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        if (bad != 0) begin errors++; $display("FAIL resp_ignore activity cycles got %0d want 0", bad); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        preload(6'd4, 32'h8899AABB);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_uns = 1'b0; req_addr = 32'h12; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (mem_wen !== 1'b1 || mem_wdata !== 32'hBEEFAABB) begin
            errors++; $display("FAIL reset_mid WR wen/wdata got %b/%h want 1/beefaabb", mem_wen, mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mid wen drop got %b want 0", mem_wen); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid resp_valid got %b want 0", resp_valid); end
        checks += 3;
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_wen !== 1'b0) bad++;
        end
        if (bad != 0) begin errors++; $display("FAIL reset_mid activity cycles got %0d want 0", bad); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid ready got %b want 1", req_ready); end
        if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL reset_mid word10 got %h want 8899aabb", mem[4]); end
        checks += 3;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_resp_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
